// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-requester round-robin RAM arbiter with burst limiting and tagged read return
module ram_access_arbiter #(
   parameter int pAdrsWidth = 16,
   parameter int pDqWidth   = 16,
   parameter int pRdLatency = 2,
   parameter int pMaxBurst  = 4
)(
   input  logic                    iSCLK,
   input  logic                    inSRST,
   input  logic                    iEn,
   input  logic [1:0]              iReq,
   input  logic [1:0]              iWe,
   input  logic [2*pAdrsWidth-1:0] iAdrs,
   input  logic [2*pDqWidth-1:0]   iWd,
   output logic [1:0]              oAck,
   output logic [pDqWidth-1:0]     oRd,
   output logic [1:0]              oRdVd,
   output logic                    oRamEn,
   output logic                    oRamWe,
   output logic [pAdrsWidth-1:0]   oRamAdrs,
   output logic [pDqWidth-1:0]     oRamWd,
   input  logic [pDqWidth-1:0]     iRamRd,
   output logic                    oBusy
);
   localparam logic [3:0] lMaxBurst = 4'(pMaxBurst);
   logic ptr, last, grant, win, hold;
   logic [1:0] elig;
   logic [3:0] cnt, cntNext;
   logic [pRdLatency-1:0][1:0] tag;
   // Pick a winner; the burst owner keeps the slot across its own ack cycle while it still requests
   always_comb begin
      elig = iEn ? iReq & ~oAck : 2'b00;
      hold = oAck[ptr] & iReq[ptr] & (cnt < lMaxBurst);
      grant = &elig ? ptr : elig[1];
      win = |elig & ~hold;
      cntNext = (grant == last && cnt != 4'd0) ? (cnt == 4'd15 ? cnt : cnt + 4'd1) : 4'd1;
   end
   // Register the RAM command, the ack pulse and the burst/pointer state
   always_ff @(posedge iSCLK or negedge inSRST) begin
      if (!inSRST) begin
         oAck <= 2'b00;
         oRamEn <= 1'b0;
         oRamWe <= 1'b0;
         oRamAdrs <= '0;
         oRamWd <= '0;
         ptr <= 1'b0;
         last <= 1'b0;
         cnt <= 4'd0;
      end else begin
         oAck <= win ? (grant ? 2'b10 : 2'b01) : 2'b00;
         oRamEn <= win;
         if (win) begin
            oRamWe <= iWe[grant];
            oRamAdrs <= grant ? iAdrs[2*pAdrsWidth-1 -: pAdrsWidth] : iAdrs[pAdrsWidth-1:0];
            oRamWd <= grant ? iWd[2*pDqWidth-1 -: pDqWidth] : iWd[pDqWidth-1:0];
            cnt <= cntNext;
            last <= grant;
            ptr <= (cntNext >= lMaxBurst) ? ~grant : grant;
         end
      end
   end
   // Read tags ride a shift register alongside the RAM latency; the ack of the issue cycle names the owner
   always_ff @(posedge iSCLK or negedge inSRST) begin
      if (!inSRST) begin
         tag <= '0;
         oRdVd <= 2'b00;
         oRd <= '0;
      end else begin
         tag[0] <= oRamWe ? 2'b00 : oAck;
         for (int k = 1; k < pRdLatency; k++) tag[k] <= tag[k-1];
         oRdVd <= tag[pRdLatency-1];
         oRd <= iRamRd;
      end
   end
   assign oBusy = oRamEn | (|tag) | (|oRdVd);
endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 SHALL have parameter pAdrsWidth, default 16: RAM word-address width.
REQ-002 SHALL have parameter pDqWidth, default 16: RAM data width.
REQ-003 SHALL have parameter pRdLatency, default 2: cycles from oRamEn (read) to valid iRamRd; legal range 1..8.
REQ-004 SHALL have parameter pMaxBurst, default 4: maximum consecutive accepts to one requester while the other requests; legal range 1..15.
REQ-005 SHALL have port iSCLK, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port inSRST, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port iEn, input, 1: arbiter enable; low blocks new accepts.
REQ-008 SHALL have port iReq, input, 2: per-requester access request.
REQ-009 SHALL have port iWe, input, 2: per-requester 1=write, 0=read.
REQ-010 SHALL have port iAdrs, input, 2*pAdrsWidth: requester i address in bits [i*pAdrsWidth +: pAdrsWidth].
REQ-011 SHALL have port iWd, input, 2*pDqWidth: requester i write data, same packing.
REQ-012 SHALL have port oAck, output, 2: one-cycle accept pulse per requester.
REQ-013 SHALL have port oRd, output, pDqWidth: shared read-return data.
REQ-014 SHALL have port oRdVd, output, 2: one-hot read-return valid, tags owner of oRd.
REQ-015 SHALL have ports oRamEn (1), oRamWe (1), oRamAdrs (pAdrsWidth), oRamWd (pDqWidth), outputs: registered RAM command.
REQ-016 SHALL have port iRamRd, input, pDqWidth: RAM read data.
REQ-017 SHALL have port oBusy, output, 1: high while oRamEn is high or any read is in flight.

Function
REQ-018 Acceptance SHALL occur at a rising edge where iEn=1 and the arbitration winner i has iReq[i]=1 and oAck[i]=0.
REQ-019 At acceptance, oAck[i], oRamEn, oRamWe=iWe[i], oRamAdrs, oRamWd SHALL be registered from requester i and be valid for exactly the following cycle; otherwise oRamEn=0, oAck=0.
REQ-020 A requester SHALL NOT be accepted in the cycle its oAck is high; it must hold iReq/iWe/iAdrs/iWd stable until oAck and may present the next access in the oAck cycle.
REQ-021 At most one acceptance per cycle; alternating requesters SHALL achieve one access per cycle; a single requester SHALL achieve one access per two cycles.
REQ-022 Arbitration: only one eligible requester -> it wins; both eligible -> round-robin pointer decides, pointer initially requester 0.
REQ-023 Burst counter (4 bits) SHALL count consecutive accepts to the same requester; reset to 1 on switch; pointer SHALL move to the other requester when count reaches pMaxBurst, or immediately after any accept if the other requester is eligible and count>=pMaxBurst.
REQ-024 With both continuously requesting, pMaxBurst=1, grants SHALL strictly alternate 0,1,0,1.
REQ-025 Reads SHALL push requester ID into a pRdLatency-deep tag shift register; oRd SHALL be iRamRd registered and oRdVd one-hot asserted pRdLatency+1 cycles after the oRamEn cycle.
REQ-026 Writes SHALL produce no oRdVd.
REQ-027 iEn deassert SHALL block new accepts only; in-flight reads SHALL complete; oBusy SHALL fall the cycle after the last oRdVd.
REQ-028 iReq dropped before oAck SHALL cancel the request with no RAM access.

Reset
REQ-029 inSRST=0 SHALL asynchronously force oAck=0, oRdVd=0, oRd=0, oRamEn=0, oRamWe=0, oRamAdrs=0, oRamWd=0, oBusy=0, pointer=0, burst count=0, tag pipeline cleared.
REQ-030 Reset mid-operation SHALL discard in-flight reads; no oRdVd SHALL appear after release for pre-reset accesses.

Verification
REQ-031 Req0 write adrs 0x0011 data 0x0035 -> oAck[0] one cycle, oRamEn=1, oRamWe=1, oRamAdrs=0x0011, oRamWd=0x0035, no oRdVd.
REQ-032 Req1 read 0x0010, RAM model returns 0xBEEF, pRdLatency=2 -> oRdVd=2'b10, oRd=0xBEEF exactly 3 cycles after oRamEn.
REQ-033 Both requesting continuously, pMaxBurst=4 -> accept sequence 0,0,0,0,1,1,1,1 (each interleave legal per REQ-020), no cycle with two oAck bits.
REQ-034 iEn dropped with 2 reads in flight -> no new oRamEn, both oRdVd delivered, oBusy low next cycle.
REQ-035 inSRST asserted one cycle after a read accept -> all outputs 0 immediately; after release, no oRdVd for 10 cycles with iReq=0.
